// File: rtl/sha3_padder.sv
// SHA-3 message padder: packs 32-bit words into a rate-sized block and applies
// the 0x06 ... 0x80 domain/pad bytes after the final word.
module sha3_padder #(
   parameter int RATE_WORDS = 34
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               in,
   input  logic                      in_ready,
   input  logic                      is_last,
   input  logic [1:0]                byte_num,
   output logic                      buffer_full,
   output logic [32*RATE_WORDS-1:0]  out,
   input  logic                      f_ack,
   output logic                      done
);

   localparam int CW = $clog2(RATE_WORDS + 1);

   typedef enum logic [1:0] {ABSORB, ZEROFILL, DONE} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [CW-1:0]            r_cnt;
   logic                     r_full;
   logic [32*RATE_WORDS-1:0] r_out;

   logic                     w_accept;
   logic                     w_shift;
   logic                     w_release;
   logic                     w_last_slot;
   logic                     w_padding;
   logic [31:0]              w_pad;
   logic [31:0]              w_word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ABSORB;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ABSORB:   if (w_accept && is_last) w_next = ZEROFILL;
         ZEROFILL: if (w_release)           w_next = DONE;
         default:                           w_next = DONE;
      endcase
   end

   always_comb begin
      w_accept    = (r_state == ABSORB) && in_ready && !r_full;
      w_shift     = w_accept || ((r_state == ZEROFILL) && !r_full);
      w_release   = r_full && f_ack && (r_state != DONE);
      w_last_slot = (r_cnt == CW'(RATE_WORDS - 1));
      w_padding   = (r_state == ZEROFILL) || is_last;

      case (byte_num)
         2'd0:    w_pad = 32'h0600_0000;
         2'd1:    w_pad = {in[31:24], 24'h06_0000};
         2'd2:    w_pad = {in[31:16], 16'h0600};
         default: w_pad = {in[31:8],  8'h06};
      endcase

      w_word = 32'h0;
      if (r_state == ABSORB) w_word = is_last ? w_pad : in;
      // closing pad bit goes on whichever word fills the final slot of the padded block
      if (w_last_slot && w_padding) w_word[7] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out  <= '0;
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else if (w_release) begin
         r_full <= 1'b0;
      end else if (w_shift) begin
         r_out <= {r_out[32*RATE_WORDS-33:0], w_word};
         if (w_last_slot) begin
            r_cnt  <= '0;
            r_full <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

   assign out         = r_out;
   assign buffer_full = r_full;
   assign done        = (r_state == DONE);

endmodule

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 Parameter RATE_WORDS, default 34, block rate in 32-bit words (34 = SHA3-256 1088-bit rate; 42 = SHAKE128).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in  input  32  message word, byte 0 in bits [31:24].
REQ-005 in_ready  input  1  `in` valid this cycle.
REQ-006 is_last  input  1  current word is the final message word; qualified by in_ready.
REQ-007 byte_num  input  2  valid bytes in the final word (0..3), MSB-first; meaningful only with is_last.
REQ-008 buffer_full  output  1  `out` holds a complete rate block; upstream input is not accepted.
REQ-009 out  output  32*RATE_WORDS  assembled block; first word accepted in the most significant 32 bits.
REQ-010 f_ack  input  1  permutation has consumed `out`; releases the buffer.
REQ-011 done  output  1  final padded block has been acknowledged.

Function
REQ-012 A word is accepted on a rising edge when in_ready=1, buffer_full=0, the state is ABSORB and done=0.
REQ-013 On acceptance, `out` shifts left by 32 bits and the new word enters bits [31:0], and the word counter increments.
REQ-014 The states are ABSORB, ZEROFILL and DONE.
REQ-015 Accepting a word with is_last=0 stays in ABSORB.
REQ-016 Accepting a word with is_last=1 stores a pad word and moves to ZEROFILL.
REQ-017 The pad word keeps the first byte_num bytes of `in` (MSB-first), places 0x06 in the next byte, and zeroes the remaining bytes.
REQ-018 The pad word for byte_num=0,1,2,3 with in=0x90ABCDEF is 0x06000000, 0x90060000, 0x90AB0600 and 0x90ABCD06 respectively.
REQ-019 In ZEROFILL with buffer_full=0, one 0x00000000 word is shifted in per cycle, independent of in_ready.
REQ-020 The word entering position RATE_WORDS-1 (the last slot of a block) during padding has bit 7 ORed with 1.
REQ-021 If the pad word itself lands in the last slot, its low byte is 0x06|0x80=0x86 (byte_num=3) or the pad byte plus trailing 0x80.
REQ-022 buffer_full rises in the cycle after the counter reaches RATE_WORDS, and the counter then resets to 0.
REQ-023 While buffer_full=1, `out` and the counter are frozen.
REQ-024 f_ack=1 with buffer_full=1 clears buffer_full on the next edge.
REQ-025 f_ack with buffer_full=0 is ignored.
REQ-026 An input present in the same cycle as f_ack is not accepted in that cycle; it may be accepted from the next cycle.
REQ-027 A block completed while in ZEROFILL, once acknowledged, moves the block to DONE and sets done=1.
REQ-028 In DONE, in_ready and f_ack are ignored, buffer_full=0, and `out` holds its last value until reset.
REQ-029 Latency: a block completed by the final accepted word shows buffer_full=1 one cycle after that word's edge.
REQ-030 Padding a partial block takes RATE_WORDS-count cycles of zero fill after the pad word.

Reset
REQ-031 reset=1 asynchronously forces out=0, buffer_full=0, done=0, counter=0 and state=ABSORB, and the block stays in that state while reset is held.
REQ-032 Reset asserted mid-block or mid-ZEROFILL discards all partial data, and no pending block is reported.

Verification
REQ-033 Single word: in=0x90ABCDEF, is_last=1, byte_num=1 -> out top word 0x90060000, words 1..32 zero, word 33 = 0x00000080, buffer_full=1 after 34 cycles; f_ack -> done=1.
REQ-034 Empty message: is_last=1, byte_num=0 -> top word 0x06000000, last word 0x00000080.
REQ-035 Exactly 33 full words plus a last word with byte_num=3 and in=0x11223344 -> word 33 = 0x11223386, buffer_full=1 next cycle; f_ack -> done=1 with no extra block.
REQ-036 34 full words with is_last=0, then f_ack, then a last word with byte_num=0 -> first block shows the data unchanged; second block top word 0x06000000, last word 0x00000080.
REQ-037 Hold in_ready=1 while buffer_full=1, and pulse f_ack together with in_ready -> no word is lost or duplicated, and acceptance resumes the cycle after the ack.
REQ-038 Assert reset at word 10 of a block, then send a one-word message -> output is identical to REQ-033.
